// File: rtl/prog_loader_pkg.sv
// Shared types and frame constants for the program loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package prog_loader_pkg;

    // Loader FSM states in frame order; DONE and ERR are terminal until re-armed.
    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_B0,
        S_B1,
        S_B2,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int         BYTES_PER_WORD = 3;
    // Required value of the six unused high bits of B0.
    localparam logic [5:0] PAD_MASK       = 6'b0;
    // Payload bits carried by one word's worth of bytes (18).
    localparam int         PACKED_W       = 8 * BYTES_PER_WORD - $bits(PAD_MASK);

endpackage

// File: rtl/prog_loader_word_packer.sv
// Collects B0/B1/B2 of one instruction word, flags nonzero pad bits in B0, emits the word.
// Latency: word and word_vld are registered one cycle after the B2 transfer.
// Backpressure: none; the caller only strobes *_take on accepted bytes.
// Ports: i_clock/i_reset (sync, active-high), i_byte, i_b0_take/i_b1_take/i_b2_take,
//        o_pad_err (combinational, valid with i_b0_take), o_word, o_word_vld.
module prog_loader_word_packer
    import prog_loader_pkg::*;
(
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [7:0]          i_byte,
    input  logic                i_b0_take,
    input  logic                i_b1_take,
    input  logic                i_b2_take,
    output logic                o_pad_err,
    output logic [PACKED_W-1:0] o_word,
    output logic                o_word_vld
);

    logic [1:0]          hi_q,   hi_d;
    logic [7:0]          mid_q,  mid_d;
    logic [PACKED_W-1:0] word_q, word_d;
    logic                vld_q,  vld_d;

    // Only the top six bits of B0 are padding; the low two carry word[17:16].
    assign o_pad_err = i_b0_take && (i_byte[7:2] != PAD_MASK);

    always_comb begin
        hi_d   = hi_q;
        mid_d  = mid_q;
        word_d = word_q;
        vld_d  = 1'b0;
        if (i_b0_take) begin
            hi_d = i_byte[1:0];
        end
        if (i_b1_take) begin
            mid_d = i_byte;
        end
        if (i_b2_take) begin
            word_d = {hi_q, mid_q, i_byte};
            vld_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            hi_q   <= '0;
            mid_q  <= '0;
            word_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            mid_q  <= mid_d;
            word_q <= word_d;
            vld_q  <= vld_d;
        end
    end

    assign o_word     = word_q;
    assign o_word_vld = vld_q;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: framed byte stream -> 18-bit words in program memory, XOR checksum, CPU hold.
// Latency: write strobe one cycle after the B2 transfer; status flags registered with the state.
// Backpressure: o_ready high in LEN_HI..CSUM; i_valid low stalls indefinitely with state held.
// Ports: i_clock, i_reset (sync, active-high), i_valid/i_byte/o_ready byte input,
//        i_restart (re-arm from DONE/ERR), o_wEn/o_wAddr/o_wData memory write,
//        o_cpuHold, o_done, o_err status. Vectors use bit 0 = MSB.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                WORD_W    = 18,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_valid,
    input  logic [0:7]      i_byte,
    output logic            o_ready,
    input  logic            i_restart,
    output logic            o_wEn,
    output logic [0:ADDR_W-1] o_wAddr,
    output logic [0:WORD_W-1] o_wData,
    output logic            o_cpuHold,
    output logic            o_done,
    output logic            o_err
);

    state_t            state_q,      state_d;
    logic [7:0]        len_hi_q,     len_hi_d;
    logic [15:0]       words_left_q, words_left_d;
    logic [7:0]        csum_q,       csum_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [ADDR_W-1:0] waddr_q,      waddr_d;
    logic              ready_q,      ready_d;
    logic              cpu_hold_q,   cpu_hold_d;
    logic              done_q,       done_d;
    logic              err_q,        err_d;

    logic [7:0]        byte_n;     // MSB-first port byte, renumbered [7:0]
    logic              xfer;
    logic              pad_err;
    logic [WORD_W-1:0] word;
    logic              word_vld;

    assign byte_n = i_byte;
    assign xfer   = i_valid && ready_q;

    prog_loader_word_packer u_packer (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_byte     (byte_n),
        .i_b0_take  (xfer && (state_q == S_B0)),
        .i_b1_take  (xfer && (state_q == S_B1)),
        .i_b2_take  (xfer && (state_q == S_B2)),
        .o_pad_err  (pad_err),
        .o_word     (word),
        .o_word_vld (word_vld)
    );

    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        words_left_d = words_left_q;
        csum_d       = csum_q;
        addr_d       = addr_q;
        waddr_d      = waddr_q;
        case (state_q)
            S_LEN_HI: if (xfer) begin
                len_hi_d = byte_n;
                state_d  = S_LEN_LO;
            end
            S_LEN_LO: if (xfer) begin
                words_left_d = {len_hi_q, byte_n};
                state_d      = ({len_hi_q, byte_n} == 16'd0) ? S_CSUM : S_B0;
            end
            S_B0: if (xfer) begin
                csum_d  = csum_q ^ byte_n;
                state_d = pad_err ? S_ERR : S_B1;
            end
            S_B1: if (xfer) begin
                csum_d  = csum_q ^ byte_n;
                state_d = S_B2;
            end
            S_B2: if (xfer) begin
                csum_d       = csum_q ^ byte_n;
                // Address for the write the packer emits next cycle; wraps naturally.
                waddr_d      = addr_q;
                addr_d       = addr_q + ADDR_W'(1);
                words_left_d = words_left_q - 16'd1;
                state_d      = (words_left_q == 16'd1) ? S_CSUM : S_B0;
            end
            S_CSUM: if (xfer) begin
                state_d = (byte_n == csum_q) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: if (i_restart) begin
                state_d = S_LEN_HI;
                csum_d  = '0;
                addr_d  = BASE_ADDR;
            end
            default: state_d = S_LEN_HI;
        endcase

        // Status outputs follow the next state so they change on the same edge.
        ready_d    = (state_d != S_DONE) && (state_d != S_ERR);
        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= S_LEN_HI;
            len_hi_q     <= '0;
            words_left_q <= '0;
            csum_q       <= '0;
            addr_q       <= BASE_ADDR;
            waddr_q      <= BASE_ADDR;
            ready_q      <= 1'b1;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            words_left_q <= words_left_d;
            csum_q       <= csum_d;
            addr_q       <= addr_d;
            waddr_q      <= waddr_d;
            ready_q      <= ready_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign o_ready   = ready_q;
    assign o_wEn     = word_vld;
    assign o_wAddr   = waddr_q;
    assign o_wData   = word;
    assign o_cpuHold = cpu_hold_q;
    assign o_done    = done_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
// Latency: n/a.
// Backpressure: byte sends wait (bounded) for o_ready.
module tb_prog_loader;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic [0:7]  i_byte  = '0;
    logic        o_ready;
    logic        i_restart = 1'b0;
    logic        o_wEn;
    logic [0:15] o_wAddr;
    logic [0:17] o_wData;
    logic        o_cpuHold;
    logic        o_done;
    logic        o_err;

    int n_pass  = 0;
    int n_total = 0;
    bit gaps_en = 1'b0;

    logic [7:0]  frame_q[$];
    logic [15:0] wa_q[$];
    logic [17:0] wd_q[$];

    prog_loader dut (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_valid   (i_valid),
        .i_byte    (i_byte),
        .o_ready   (o_ready),
        .i_restart (i_restart),
        .o_wEn     (o_wEn),
        .o_wAddr   (o_wAddr),
        .o_wData   (o_wData),
        .o_cpuHold (o_cpuHold),
        .o_done    (o_done),
        .o_err     (o_err)
    );

    always #5 i_clock = ~i_clock;

    // Write trace, sampled mid-cycle.
    always @(negedge i_clock) begin
        if (o_wEn) begin
            wa_q.push_back(o_wAddr);
            wd_q.push_back(o_wData);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge i_clock);
        i_valid = 1'b1;
        i_byte  = b;
        while (!o_ready && n < 20) begin
            @(negedge i_clock);
            n++;
        end
        if (!o_ready) begin
            n_total++;
            $display("FAIL send_timeout: o_ready=%b required 1 for byte %h", o_ready, b);
        end
        @(posedge i_clock);
        #1 i_valid = 1'b0;
    endtask

    task automatic send_frame();
        foreach (frame_q[i]) begin
            if (gaps_en) repeat ($urandom_range(0, 3)) @(negedge i_clock);
            send_byte(frame_q[i]);
        end
        repeat (3) @(negedge i_clock);
    endtask

    task automatic do_restart();
        @(negedge i_clock);
        i_restart = 1'b1;
        @(posedge i_clock);
        #1 i_restart = 1'b0;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (2) @(posedge i_clock);
        #1 i_reset = 1'b0;
        @(negedge i_clock);
        n_total++; if (o_ready   !== 1'b1)  $display("FAIL rst_ready: got %b want 1", o_ready);   else n_pass++;
        n_total++; if (o_wEn     !== 1'b0)  $display("FAIL rst_wen: got %b want 0", o_wEn);       else n_pass++;
        n_total++; if (o_wAddr   !== 16'h0) $display("FAIL rst_waddr: got %h want 0", o_wAddr);   else n_pass++;
        n_total++; if (o_wData   !== 18'h0) $display("FAIL rst_wdata: got %h want 0", o_wData);   else n_pass++;
        n_total++; if (o_cpuHold !== 1'b1)  $display("FAIL rst_hold: got %b want 1", o_cpuHold);  else n_pass++;
        n_total++; if (o_done    !== 1'b0)  $display("FAIL rst_done: got %b want 0", o_done);     else n_pass++;
        n_total++; if (o_err     !== 1'b0)  $display("FAIL rst_err: got %b want 0", o_err);       else n_pass++;
    endtask

    // Two words 0x23456, 0x1ABCD; XOR of the six payload bytes is 0x07.
    task automatic test_good_load();
        wa_q.delete(); wd_q.delete();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h02); send_byte(8'h34);
        n_total++; if (o_wEn !== 1'b0) $display("FAIL early_wen: got %b want 0", o_wEn); else n_pass++;
        send_byte(8'h56);
        // One cycle after the B2 edge the write is presented.
        n_total++; if (o_wEn   !== 1'b1)     $display("FAIL lat_wen: got %b want 1", o_wEn);          else n_pass++;
        n_total++; if (o_wAddr !== 16'h0)    $display("FAIL lat_waddr: got %h want 0000", o_wAddr);   else n_pass++;
        n_total++; if (o_wData !== 18'h23456) $display("FAIL lat_wdata: got %h want 23456", o_wData); else n_pass++;
        frame_q = '{8'h01, 8'hAB, 8'hCD, 8'h07};
        send_frame();
        n_total++; if (wa_q.size() != 2) $display("FAIL good_nwr: got %0d want 2", wa_q.size()); else n_pass++;
        if (wa_q.size() == 2) begin
            n_total++; if (wa_q[1] !== 16'h1 || wd_q[1] !== 18'h1ABCD)
                $display("FAIL good_w1: got %h@%h want 1abcd@0001", wd_q[1], wa_q[1]); else n_pass++;
        end
        n_total++; if (o_done    !== 1'b1) $display("FAIL good_done: got %b want 1", o_done);    else n_pass++;
        n_total++; if (o_cpuHold !== 1'b0) $display("FAIL good_hold: got %b want 0", o_cpuHold); else n_pass++;
        n_total++; if (o_ready   !== 1'b0) $display("FAIL good_ready: got %b want 0", o_ready);  else n_pass++;
    endtask

    task automatic test_bad_csum();
        do_restart();
        n_total++; if (o_cpuHold !== 1'b1) $display("FAIL rs_hold: got %b want 1", o_cpuHold); else n_pass++;
        n_total++; if (o_done    !== 1'b0) $display("FAIL rs_done: got %b want 0", o_done);    else n_pass++;
        n_total++; if (o_ready   !== 1'b1) $display("FAIL rs_ready: got %b want 1", o_ready);  else n_pass++;
        frame_q = '{8'h00, 8'h02, 8'h02, 8'h34, 8'h56, 8'h01, 8'hAB, 8'hCD, 8'h0C};
        send_frame();
        n_total++; if (wa_q.size() != 2) $display("FAIL bad_nwr: got %0d want 2", wa_q.size()); else n_pass++;
        n_total++; if (o_err     !== 1'b1) $display("FAIL bad_err: got %b want 1", o_err);      else n_pass++;
        n_total++; if (o_done    !== 1'b0) $display("FAIL bad_done: got %b want 0", o_done);    else n_pass++;
        n_total++; if (o_cpuHold !== 1'b1) $display("FAIL bad_hold: got %b want 1", o_cpuHold); else n_pass++;
    endtask

    task automatic test_zero_len();
        do_restart();
        frame_q = '{8'h00, 8'h00, 8'h00};
        send_frame();
        n_total++; if (wa_q.size() != 0) $display("FAIL z_nwr: got %0d want 0", wa_q.size()); else n_pass++;
        n_total++; if (o_done !== 1'b1) $display("FAIL z_done: got %b want 1", o_done);       else n_pass++;
        do_restart();
        frame_q = '{8'h00, 8'h00, 8'h01};
        send_frame();
        n_total++; if (o_err  !== 1'b1) $display("FAIL z_err: got %b want 1", o_err);         else n_pass++;
        n_total++; if (o_done !== 1'b0) $display("FAIL z_err_done: got %b want 0", o_done);   else n_pass++;
    endtask

    task automatic test_pad_err();
        do_restart();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h40);
        n_total++; if (o_err   !== 1'b1) $display("FAIL pad_err: got %b want 1", o_err);     else n_pass++;
        n_total++; if (o_ready !== 1'b0) $display("FAIL pad_ready: got %b want 0", o_ready); else n_pass++;
        repeat (4) @(negedge i_clock);
        n_total++; if (wa_q.size() != 0) $display("FAIL pad_nwr: got %0d want 0", wa_q.size()); else n_pass++;
    endtask

    task automatic test_reset_midword();
        do_restart();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h03); send_byte(8'hFF);
        @(negedge i_clock);
        i_reset = 1'b1;
        @(posedge i_clock);
        #1 i_reset = 1'b0;
        n_total++; if (o_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", o_ready); else n_pass++;
        frame_q = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h12, 8'h12};
        send_frame();
        n_total++; if (wa_q.size() != 1) $display("FAIL mid_nwr: got %0d want 1", wa_q.size()); else n_pass++;
        if (wa_q.size() == 1) begin
            n_total++; if (wa_q[0] !== 16'h0 || wd_q[0] !== 18'h00012)
                $display("FAIL mid_w0: got %h@%h want 00012@0000", wd_q[0], wa_q[0]); else n_pass++;
        end
        n_total++; if (o_done !== 1'b1) $display("FAIL mid_done: got %b want 1", o_done); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] ea[2];
        logic [17:0] ed[2];
        ea = '{16'h0, 16'h1};
        ed = '{18'h23456, 18'h1ABCD};
        gaps_en = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            do_restart();
            frame_q = '{8'h00, 8'h02, 8'h02, 8'h34, 8'h56, 8'h01, 8'hAB, 8'hCD, 8'h07};
            send_frame();
            n_total++; if (wa_q.size() != 2) $display("FAIL gap_nwr%0d: got %0d want 2", pass, wa_q.size()); else n_pass++;
            if (wa_q.size() == 2) begin
                for (int k = 0; k < 2; k++) begin
                    n_total++; if (wa_q[k] !== ea[k] || wd_q[k] !== ed[k])
                        $display("FAIL gap_w%0d_%0d: got %h@%h want %h@%h", pass, k, wd_q[k], wa_q[k], ed[k], ea[k]);
                    else n_pass++;
                end
            end
            n_total++; if (o_done !== 1'b1) $display("FAIL gap_done%0d: got %b want 1", pass, o_done); else n_pass++;
        end
        gaps_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_csum();
        test_zero_len();
        test_pad_err();
        test_reset_midword();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
